// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - operand, button and result bundle for alu_seq_ctrl
interface alu_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [3:0]       op_i;
  logic             accum_mode_i;
  logic             clear_i;
  logic [WIDTH-1:0] y_o;
  logic             valid_o;
  logic             busy_o;
  logic             carry_o;
  logic             overflow_o;
  logic             zero_o;

  modport master (
    output a_i, b_i, op_i, accum_mode_i, clear_i,
    input  y_o, valid_o, busy_o, carry_o, overflow_o, zero_o
  );

  modport slave (
    input  a_i, b_i, op_i, accum_mode_i, clear_i,
    output y_o, valid_o, busy_o, carry_o, overflow_o, zero_o
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - debounced button-driven ALU with iterative shift-add multiply
// Buttons go sync -> debounce -> rising edge, so one press launches one operation.
module alu_seq_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_seq_ctrl_if.slave bus
);
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ITER_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_MUL_RUN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_sync1;
  logic [3:0]         r_sync2;
  logic [3:0]         r_deb;
  logic [3:0]         r_deb_d;
  logic [CNT_W-1:0]   r_cnt [4];
  logic [3:0]         w_start;

  logic [WIDTH-1:0]   r_y;
  logic               r_valid;
  logic               r_carry;
  logic               r_ovf;
  logic               r_zero;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [ITER_W-1:0]  r_iter;

  logic [WIDTH-1:0]   w_opa;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod_step;
  logic               w_load;
  logic               w_mul_start;
  logic [WIDTH-1:0]   w_res;
  logic               w_res_carry;
  logic               w_res_ovf;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= bus.op_i;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_start     = r_deb & ~r_deb_d;
  assign w_opa       = bus.accum_mode_i ? r_y : bus.a_i;
  assign w_sum       = {1'b0, w_opa} + {1'b0, bus.b_i};
  assign w_diff      = {1'b0, w_opa} - {1'b0, bus.b_i};
  assign w_prod_step = r_prod + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Starts are also refused while valid_o is high so result pulses never abut.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_mul_start = 1'b0;
    w_res       = '0;
    w_res_carry = 1'b0;
    w_res_ovf   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!bus.clear_i && !r_valid) begin
          if (w_start[0]) begin
            w_load      = 1'b1;
            w_res       = w_sum[WIDTH-1:0];
            w_res_carry = w_sum[WIDTH];
            w_res_ovf   = (w_opa[WIDTH-1] == bus.b_i[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != w_opa[WIDTH-1]);
          end else if (w_start[1]) begin
            w_load      = 1'b1;
            w_res       = w_diff[WIDTH-1:0];
            w_res_carry = w_diff[WIDTH];
            w_res_ovf   = (w_opa[WIDTH-1] != bus.b_i[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != w_opa[WIDTH-1]);
          end else if (w_start[2]) begin
            w_mul_start = 1'b1;
            w_state_nxt = ST_MUL_RUN;
          end else if (w_start[3]) begin
            w_load      = 1'b1;
            w_res       = w_opa ^ bus.b_i;
          end
        end
      end
      ST_MUL_RUN: begin
        if (bus.clear_i) begin
          w_state_nxt = ST_IDLE;
        end else if (r_iter == ITER_LAST) begin
          w_state_nxt = ST_IDLE;
          w_load      = 1'b1;
          w_res       = w_prod_step[WIDTH-1:0];
          w_res_carry = |w_prod_step[2*WIDTH-1:WIDTH];
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_y      <= '0;
      r_valid  <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_iter   <= '0;
    end else begin
      r_valid <= w_load;
      if (bus.clear_i) begin
        r_y     <= '0;
        r_carry <= 1'b0;
        r_ovf   <= 1'b0;
        r_zero  <= 1'b0;
      end else if (w_load) begin
        r_y     <= w_res;
        r_carry <= w_res_carry;
        r_ovf   <= w_res_ovf;
        r_zero  <= (w_res == '0);
      end
      if (w_mul_start) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_opa};
        r_mplier <= bus.b_i;
        r_prod   <= '0;
        r_iter   <= '0;
      end else if (r_state == ST_MUL_RUN) begin
        r_prod   <= w_prod_step;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_iter   <= r_iter + 1'b1;
      end
    end
  end

  assign bus.y_o        = r_y;
  assign bus.valid_o    = r_valid;
  assign bus.busy_o     = (r_state == ST_MUL_RUN);
  assign bus.carry_o    = r_carry;
  assign bus.overflow_o = r_ovf;
  assign bus.zero_o     = r_zero;
endmodule
